genius_uc: RTL

- Control unit (Moore FSM) for the Genius memory game datapath.
- Sequences that datapath through each round:
  - pick a random ROM, then play back the sequence on the LEDs (on/off phases timed by the 1000-tick counter);
  - collect and compare the player's presses, with a 5000-tick timeout;
  - grow the limit by one per round until 16 rounds are won, or end the game on error or timeout.
- Sits between the top-level game wrapper (iniciar, result LEDs) and the datapath control/status pins.

---
 rtl/genius_pkg.sv | 28 ++
 rtl/genius_uc.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius memory game control unit.
// State codes also drive the external db_estado display decoder.
package genius_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    SORTEIA     = 4'd2,
    MOSTRA      = 4'd3,
    APAGA       = 4'd4,
    PROX_LED    = 4'd5,
    INICIA_JOG  = 4'd6,
    ESPERA      = 4'd7,
    REGISTRA    = 4'd8,
    COMPARA     = 4'd9,
    PROX_JOG    = 4'd10,
    PROX_RODADA = 4'd11,
    GANHOU      = 4'd12,
    PERDEU      = 4'd13,
    TIMEOUT     = 4'd14,
    NAO_USADO   = 4'd15
  } state_t;

  localparam logic [1:0] SEL_APAGADO = 2'b00;
  localparam logic [1:0] SEL_MEMORIA = 2'b01;
  localparam logic [1:0] SEL_BOTOES  = 2'b10;

endpackage

// File: rtl/genius_uc.sv
// Moore control unit for the Genius game: shows the LED sequence each round,
// then collects and checks the player's presses with a timeout.
module genius_uc
  import genius_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       botoesIgualMemoria,
  input  logic       fimL,
  input  logic       fimM,
  input  logic       endecoIgualLimite,
  input  logic       jogada_feita,
  input  logic       timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       zeraM,
  output logic       contaM,
  output logic       registraR,
  output logic       selecionaMemoria,
  output logic       reset_random,
  output logic       contaT,
  output logic [1:0] seletor,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  state_t state_reg, state_next;

  always_ff @(posedge clock) begin
    if (!reset) state_reg <= INICIAL;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      INICIAL:     if (iniciar) state_next = PREPARA;
      PREPARA:     state_next = SORTEIA;
      SORTEIA:     state_next = MOSTRA;
      MOSTRA:      if (fimM) state_next = APAGA;
      APAGA:       if (fimM) state_next = endecoIgualLimite ? INICIA_JOG : PROX_LED;
      PROX_LED:    state_next = MOSTRA;
      INICIA_JOG:  state_next = ESPERA;
      // A press in the same cycle as the timeout still counts.
      ESPERA: begin
        if (jogada_feita)  state_next = REGISTRA;
        else if (timeout)  state_next = TIMEOUT;
      end
      REGISTRA:    state_next = COMPARA;
      COMPARA: begin
        if (!botoesIgualMemoria)     state_next = PERDEU;
        else if (!endecoIgualLimite) state_next = PROX_JOG;
        else if (fimL)               state_next = GANHOU;
        else                         state_next = PROX_RODADA;
      end
      PROX_JOG:    state_next = ESPERA;
      PROX_RODADA: state_next = MOSTRA;
      GANHOU, PERDEU, TIMEOUT: if (iniciar) state_next = PREPARA;
      default:     state_next = INICIAL;
    endcase
  end

  always_comb begin
    zeraE            = 1'b0;
    contaE           = 1'b0;
    zeraL            = 1'b0;
    contaL           = 1'b0;
    zeraR            = 1'b0;
    zeraM            = 1'b0;
    contaM           = 1'b0;
    registraR        = 1'b0;
    selecionaMemoria = 1'b0;
    reset_random     = 1'b0;
    contaT           = 1'b0;
    seletor          = SEL_APAGADO;
    pronto           = 1'b0;
    ganhou           = 1'b0;
    perdeu           = 1'b0;
    db_timeout       = 1'b0;
    unique case (state_reg)
      PREPARA: begin
        zeraE        = 1'b1;
        zeraL        = 1'b1;
        zeraR        = 1'b1;
        zeraM        = 1'b1;
        reset_random = 1'b1;
      end
      SORTEIA:  selecionaMemoria = 1'b1;
      MOSTRA: begin
        seletor = SEL_MEMORIA;
        contaM  = 1'b1;
      end
      // M wraps at terminal count, so it keeps running into the off phase.
      APAGA:    contaM = 1'b1;
      PROX_LED: contaE = 1'b1;
      INICIA_JOG: begin
        zeraE = 1'b1;
        zeraR = 1'b1;
      end
      ESPERA: begin
        seletor = SEL_BOTOES;
        contaT  = 1'b1;
      end
      REGISTRA: begin
        seletor   = SEL_BOTOES;
        registraR = 1'b1;
      end
      COMPARA:  seletor = SEL_BOTOES;
      PROX_JOG: contaE = 1'b1;
      PROX_RODADA: begin
        contaL = 1'b1;
        zeraE  = 1'b1;
        zeraR  = 1'b1;
        zeraM  = 1'b1;
      end
      GANHOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      PERDEU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      TIMEOUT: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state_reg;

endmodule
